// File: rtl/output_controller.sv
// output_controller: streams a fixed-length run of result words into BRAM port 0 with a one-cycle write latency.
// Ports: clk/rst_n (async active-low); start_run_i, run_count_i start a run; result_i/result_valid_i with ready_o handshake;
// write_o marks an active run, done_o pulses on completion, error_o is a sticky protocol error;
// addr0_o/ce0_o/we0_o/d0_o drive the BRAM write port; q0_i and port 1 are unused (port 1 tied to 0).
module output_controller #(
  parameter int CNT_WIDTH  = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_BIT    = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_run_i,
  input  logic [CNT_BIT-1:0]    run_count_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  input  logic                  result_valid_i,
  output logic                  ready_o,
  output logic                  write_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [CNT_WIDTH-1:0]  addr0_o,
  output logic                  ce0_o,
  output logic                  we0_o,
  output logic [DATA_WIDTH-1:0] d0_o,
  input  logic [DATA_WIDTH-1:0] q0_i,
  output logic [CNT_WIDTH-1:0]  addr1_o,
  output logic                  ce1_o,
  output logic                  we1_o,
  output logic [DATA_WIDTH-1:0] d1_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_BIT:0] MAX_RUN = (CNT_BIT+1)'(1) << CNT_WIDTH;
  logic [1:0] state;
  logic [CNT_WIDTH-1:0] cnt, last_idx;
  logic accept, last, zero_run, over_run, idle_start, unused_q0;
  assign ready_o    = state == RUN;
  assign write_o    = state == RUN || state == DONE;
  assign done_o     = state == DONE;
  assign accept     = result_valid_i & ready_o;
  assign last       = cnt == last_idx;
  assign zero_run   = run_count_i == '0;
  assign over_run   = {1'b0, run_count_i} > MAX_RUN;
  assign idle_start = state == IDLE && start_run_i;
  assign addr1_o    = '0;
  assign ce1_o      = 1'b0;
  assign we1_o      = 1'b0;
  assign d1_o       = '0;
  assign unused_q0  = ^q0_i;
  // The run length is held as the index of the final word so that a full 2**CNT_WIDTH run fits in CNT_WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_idx <= '0;
      error_o  <= 1'b0;
      ce0_o    <= 1'b0;
      we0_o    <= 1'b0;
      addr0_o  <= '0;
      d0_o     <= '0;
    end else begin
      ce0_o <= accept;
      we0_o <= accept;
      if (accept) begin
        d0_o    <= result_i;
        addr0_o <= cnt;
        cnt     <= cnt + CNT_WIDTH'(1);
      end
      if (idle_start && !zero_run && !over_run) begin
        state    <= RUN;
        cnt      <= '0;
        last_idx <= CNT_WIDTH'(run_count_i - CNT_BIT'(1));
        error_o  <= 1'b0;
      end else if (idle_start && zero_run) begin
        state <= DONE;
      end else if (state == RUN && accept && last) begin
        state <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
      if ((result_valid_i && !ready_o) || (idle_start && over_run)) error_o <= 1'b1;
    end
  end
endmodule

// File: doc/output_controller.md
OUTPUT_CONTROLLER -- requirements
Module: output_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 12, meaning BRAM address width and write-counter width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the result word width.
REQ-003 SHALL have parameter CNT_BIT, default 31, meaning the run_count_i width.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports as follows: clk in 1 (rising-edge clock); rst_n in 1 (asynchronous active-low reset).
REQ-005 SHALL have ports:
- start_run_i in 1: one-cycle run start request.
- run_count_i in CNT_BIT: number of result words to store, sampled at start.
- result_i in DATA_WIDTH: result word from the core controller.
- result_valid_i in 1: result_i is valid this cycle.
- ready_o out 1: controller accepts a word this cycle.
- write_o out 1: run in progress, to the top module.
- done_o out 1: one-cycle run-complete pulse.
- error_o out 1: sticky protocol error flag.
- addr0_o out CNT_WIDTH, ce0_o out 1, we0_o out 1, d0_o out DATA_WIDTH: BRAM port 0 write side.
- q0_i in DATA_WIDTH: BRAM port 0 read data, unused.
- addr1_o out CNT_WIDTH, ce1_o out 1, we1_o out 1, d1_o out DATA_WIDTH: BRAM port 1, unused.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, DONE, with reset state IDLE.
REQ-007 In IDLE, when start_run_i=1 and 1 <= run_count_i <= 2**CNT_WIDTH, SHALL latch run_count_i, clear the word counter cnt to 0, clear error_o, and go to RUN.
REQ-008 In IDLE, when start_run_i=1 and run_count_i=0, SHALL go directly to DONE without issuing any BRAM write.
REQ-009 In IDLE, when start_run_i=1 and run_count_i > 2**CNT_WIDTH, SHALL set error_o, stay in IDLE, and issue no write.
REQ-010 SHALL drive ready_o=1 only in RUN (combinational from state) and SHALL drive write_o=1 in RUN and DONE.
REQ-011 A word is accepted when result_valid_i and ready_o are both 1 at a rising edge; on acceptance SHALL register result_i to d0_o and cnt to addr0_o, and set ce0_o=we0_o=1 for exactly the following cycle (write latency 1).
REQ-012 On each acceptance SHALL increment cnt by 1, modulo 2**CNT_WIDTH.
REQ-013 When the accepted word is word run_count-1, SHALL go to DONE; the final write strobe and done_o SHALL be high in the same cycle.
REQ-014 SHALL hold done_o high for exactly one cycle in DONE, then return to IDLE.
REQ-015 When not strobing a write, SHALL hold ce0_o=we0_o=0; addr0_o and d0_o hold their last values.
REQ-016 Consecutive accepted words SHALL produce back-to-back writes at consecutive addresses with no bubble.
REQ-017 result_valid_i=1 while ready_o=0 SHALL set error_o (sticky) and the word SHALL be dropped; error_o clears only on a valid start per REQ-007.
REQ-018 start_run_i while in RUN or DONE SHALL be ignored and SHALL NOT affect cnt, state, or error_o.
REQ-019 Port 1 outputs SHALL be tied to 0; q0_i SHALL be ignored.

Reset
REQ-020 Asserting rst_n low SHALL immediately force state to IDLE, cnt to 0, and all outputs (ready_o, write_o, done_o, error_o, ce0_o, we0_o, addr0_o, d0_o) to 0, including in the middle of a run; any pending write strobe SHALL be cancelled.
REQ-021 After rst_n is released, SHALL take no action until a new start_run_i.

Verification
REQ-022 Start with run_count_i=4, then drive valid on 4 consecutive cycles with data A0..A3 -> writes at addr 0..3 on 4 consecutive cycles; done_o is high with the addr-3 write; ready_o falls after the 4th acceptance.
REQ-023 Run_count_i=3 with valid gapped (1,0,1,0,1) -> exactly 3 writes at addr 0,1,2; no write strobe in gap cycles; done_o pulses once.
REQ-024 Run_count_i=0 -> no ce0_o; done_o high exactly one cycle two edges after start; error_o stays 0.
REQ-025 Run_count_i=4097 (CNT_WIDTH=12) -> error_o=1; state stays IDLE; no write. A following valid start with run_count_i=2 -> error_o=0.
REQ-026 Valid asserted in IDLE -> error_o=1, no write. Separately, rst_n pulsed low after 2 of 5 words -> all outputs 0 immediately; a new start with run_count_i=5 writes addr 0..4.
REQ-027 Run with run_count_i=4096 -> final write at addr 4095, done_o high with it, cnt wraps to 0.
